rca_nibble_sequencer: RTL and testbench



---
 rtl/rca_pkg.sv | 11 +
 rtl/rca4_slice.sv | 24 ++
 rtl/rca_nibble_sequencer.sv | 116 +++++++++++
 tb/tb_rca_nibble_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared constants and FSM encoding for the nibble-serial adder
package rca_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rca4_slice.sv
// rtl/rca4_slice.sv - combinational 4-bit ripple-carry adder slice
module rca4_slice
  import rca_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  // one full adder per bit, carry rippling upward
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/rca_nibble_sequencer.sv
// rtl/rca_nibble_sequencer.sv - WIDTH-bit adder built from one reused 4-bit slice
module rca_nibble_sequencer
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_t                state;
  state_t                state_next;
  logic [WIDTH-1:0]      a_sh;
  logic [WIDTH-1:0]      b_sh;
  logic [WIDTH-1:0]      sum_sh;
  logic [WIDTH-1:0]      sum_next;
  logic                  carry;
  logic [IDXW-1:0]       idx;
  logic [NIBBLE_W-1:0]   slice_s;
  logic                  slice_co;
  logic                  accept;
  logic                  step;
  logic                  finish;

  rca4_slice u_slice (
    .a  (a_sh[NIBBLE_W-1:0]),
    .b  (b_sh[NIBBLE_W-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // new nibble enters at the top; after NIBBLES steps the register holds the full sum
  assign sum_next = WIDTH'({slice_s, sum_sh} >> NIBBLE_W);

  assign busy = (state == ST_RUN);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state and per-cycle control strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (idx == LAST_IDX) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // operand/result shifting, carry hold and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        carry  <= cin;
        idx    <= '0;
        sum_sh <= '0;
      end else if (step) begin
        carry  <= slice_co;
        sum_sh <= sum_next;
        a_sh   <= a_sh >> NIBBLE_W;
        b_sh   <= b_sh >> NIBBLE_W;
        idx    <= idx + IDXW'(1);
        if (finish) begin
          sum  <= sum_next;
          cout <= slice_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// tb/tb_rca_nibble_sequencer.sv - scoreboard bench for the nibble-serial adder
module tb_rca_nibble_sequencer;

  typedef struct {
    logic [15:0] s;
    logic        c;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        cin8;
  logic        busy8;
  logic        done8;
  logic [7:0]  sum8;
  logic        cout8;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  rca_nibble_sequencer #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  rca_nibble_sequencer #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] r;
    exp_t e;
    r   = {1'b0, x} + {1'b0, y} + {16'd0, c};
    e.s = r[15:0];
    e.c = r[16];
    return e;
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h4321;
    cin   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, sum, cout} !== 19'd0)
      $display("FAIL reset_outputs busy=%b done=%b sum=%h cout=%b required all 0", busy, done, sum, cout);
    else n_pass++;
    n_checks++;
    if ({busy8, done8, sum8, cout8} !== 11'd0)
      $display("FAIL reset_outputs8 busy=%b done=%b sum=%h cout=%b required all 0", busy8, done8, sum8, cout8);
    else n_pass++;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_no_start busy=%b done=%b required 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic do_op(input string name, input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
    exp_t e;
    exp_t hold;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    exp_q.push_back(model(ta, tb_v, tc));
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
      cin   = 1'($urandom);
      if (i < 5) begin
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0)
          $display("FAIL %s_run%0d busy=%b done=%b required 1 0", name, i, busy, done);
        else n_pass++;
      end else begin
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1)
          $display("FAIL %s_done busy=%b done=%b required 0 1", name, busy, done);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s_result scoreboard empty sum=%h cout=%b", name, sum, cout);
        end else begin
          e = exp_q.pop_front();
          if (sum !== e.s || cout !== e.c)
            $display("FAIL %s_result sum=%h cout=%b required sum=%h cout=%b", name, sum, cout, e.s, e.c);
          else n_pass++;
        end
      end
    end
    hold.s = sum;
    hold.c = cout;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || sum !== hold.s || cout !== hold.c)
      $display("FAIL %s_after done=%b sum=%h cout=%b required done=0 sum=%h cout=%b",
               name, done, sum, cout, hold.s, hold.c);
    else n_pass++;
  endtask

  task automatic test_basic();
    do_op("basic", 16'h1234, 16'h4321, 1'b0);
  endtask

  task automatic test_carry_chain();
    do_op("carry_ffff_1", 16'hFFFF, 16'h0001, 1'b0);
    do_op("carry_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   dones;
    @(negedge clk);
    a     = 16'hA5C3;
    b     = 16'h3C7E;
    cin   = 1'b1;
    start = 1'b1;
    exp_q.push_back(model(16'hA5C3, 16'h3C7E, 1'b1));
    dones = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (i == 5 || i == 10) begin
        n_checks++;
        if (done !== 1'b1)
          $display("FAIL b2b_done_at_%0d done=%b required 1", i, done);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_result_%0d scoreboard empty sum=%h", i, sum);
        end else begin
          e = exp_q.pop_front();
          if (sum !== e.s || cout !== e.c)
            $display("FAIL b2b_result_%0d sum=%h cout=%b required sum=%h cout=%b", i, sum, cout, e.s, e.c);
          else n_pass++;
        end
      end
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      if (i == 5) begin
        exp_q.push_back(model(a, b, cin));
      end else if (i == 6) begin
        start = 1'b0;
      end
    end
    n_checks++;
    if (dones !== 2)
      $display("FAIL b2b_done_count count=%0d required 2", dones);
    else n_pass++;
    start = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int dones;
    @(negedge clk);
    a     = 16'h7777;
    b     = 16'h9999;
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0)
      $display("FAIL midrun_reset busy=%b done=%b sum=%h cout=%b required 0 0 0000 0", busy, done, sum, cout);
    else n_pass++;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0)
      $display("FAIL midrun_no_done activity_cycles=%0d required 0", dones);
    else n_pass++;
    do_op("after_reset", 16'h0F0F, 16'h00F1, 1'b0);
  endtask

  task automatic test_width8();
    logic [8:0] r;
    @(negedge clk);
    a8     = 8'h9C;
    b8     = 8'h7A;
    cin8   = 1'b1;
    start8 = 1'b1;
    r = {1'b0, 8'h9C} + {1'b0, 8'h7A} + 9'd1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      if (i < 3) begin
        n_checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0)
          $display("FAIL w8_run%0d busy=%b done=%b required 1 0", i, busy8, done8);
        else n_pass++;
      end else begin
        n_checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || sum8 !== r[7:0] || cout8 !== r[8])
          $display("FAIL w8_result done=%b busy=%b sum=%h cout=%b required done=1 busy=0 sum=%h cout=%b",
                   done8, busy8, sum8, cout8, r[7:0], r[8]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    start8   = 1'b0;
    a8       = '0;
    b8       = '0;
    cin8     = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_to_back();
    test_reset_midrun();
    test_width8();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
